// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing the main-memory port between CPU read pulses and io_unit accesses.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT watchdog that forces completion after TIMEOUT cycles.
module mem_access_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 37,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_from_pulse,
    input  logic [ADDR_W-1:0] addr_from_sel,
    output logic              mem_read_reply_to_pulse,
    output logic [DATA_W-1:0] rdata_to_ac,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_reply,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              overrun_err,
    output logic              timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;

    state_t            state_q;
    logic              owner_q;
    logic              last_grant_q;
    logic              cpu_pend_q, cpu_pend_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_to_ac_q;
    logic [DATA_W-1:0] io_rdata_q;
    logic              cpu_reply_q;
    logic              io_ack_q;
    logic              overrun_q;

    logic cpu_busy, cpu_want, pick_cpu, grant_cpu, grant_io, overrun_hit;
    logic done_reply, done_timeout;

    // A CPU pulse arriving this cycle already counts as a request, so round-robin is
    // honoured against a simultaneous io_req; the CPU grant itself waits for the latch.
    always_comb begin
        cpu_busy    = (state_q != S_IDLE) && (owner_q == OWN_CPU);
        overrun_hit = mem_read_from_pulse && (cpu_pend_q || cpu_busy);
        cpu_want    = cpu_pend_q || mem_read_from_pulse;
        if (cpu_want && io_req) begin
            pick_cpu = (last_grant_q == OWN_IO);
        end else begin
            pick_cpu = cpu_want;
        end
        grant_cpu = (state_q == S_IDLE) && pick_cpu && cpu_pend_q;
        grant_io  = (state_q == S_IDLE) && !pick_cpu && io_req;

        cpu_pend_d = cpu_pend_q;
        cpu_addr_d = cpu_addr_q;
        if (grant_cpu) begin
            cpu_pend_d = 1'b0;
        end else if (mem_read_from_pulse && !overrun_hit) begin
            cpu_pend_d = 1'b1;
            cpu_addr_d = addr_from_sel;
        end

        done_reply = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && mem_reply;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_q;

    assign done_timeout = (state_q == S_WAIT) && !mem_reply
                          && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q == S_ISSUE) begin
                wait_cnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
            if (done_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign done_timeout = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            owner_q       <= OWN_CPU;
            last_grant_q  <= OWN_IO;
            cpu_pend_q    <= 1'b0;
            cpu_addr_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_to_ac_q <= '0;
            io_rdata_q    <= '0;
            cpu_reply_q   <= 1'b0;
            io_ack_q      <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            cpu_pend_q  <= cpu_pend_d;
            cpu_addr_q  <= cpu_addr_d;
            overrun_q   <= overrun_q | overrun_hit;
            mem_req_q   <= 1'b0;
            cpu_reply_q <= 1'b0;
            io_ack_q    <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (grant_cpu) begin
                        mem_addr_q   <= cpu_addr_q;
                        mem_we_q     <= 1'b0;
                        mem_wdata_q  <= '0;
                        owner_q      <= OWN_CPU;
                        last_grant_q <= OWN_CPU;
                        mem_req_q    <= 1'b1;
                        state_q      <= S_ISSUE;
                    end else if (grant_io) begin
                        mem_addr_q   <= io_addr;
                        mem_we_q     <= io_we;
                        mem_wdata_q  <= io_wdata;
                        owner_q      <= OWN_IO;
                        last_grant_q <= OWN_IO;
                        mem_req_q    <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (done_reply || done_timeout) begin
                        state_q <= S_RESP;
                        if (owner_q == OWN_CPU) begin
                            cpu_reply_q   <= 1'b1;
                            rdata_to_ac_q <= done_reply ? mem_rdata : '0;
                        end else begin
                            io_ack_q <= 1'b1;
                            if (!mem_we_q) begin
                                io_rdata_q <= done_reply ? mem_rdata : '0;
                            end
                        end
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req                 = mem_req_q;
    assign mem_we                  = mem_we_q;
    assign mem_addr                = mem_addr_q;
    assign mem_wdata               = mem_wdata_q;
    assign mem_read_reply_to_pulse = cpu_reply_q;
    assign rdata_to_ac             = rdata_to_ac_q;
    assign io_ack                  = io_ack_q;
    assign io_rdata                = io_rdata_q;
    assign overrun_err             = overrun_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized bench for mem_access_arbiter: a memory responder plus a transaction-level model
// (round-robin order, reference memory contents) predicts every memory access and reply.
module tb_mem_access_arbiter;

    localparam int AW       = 12;
    localparam int DW       = 37;
    localparam int TO       = 8;
    localparam int NO_REPLY = -1;
    localparam int LOG_N    = 2048;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_read_from_pulse = 1'b0;
    logic [AW-1:0] addr_from_sel = '0;
    logic          mem_read_reply_to_pulse;
    logic [DW-1:0] rdata_to_ac;
    logic          io_req = 1'b0;
    logic          io_we = 1'b0;
    logic [AW-1:0] io_addr = '0;
    logic [DW-1:0] io_wdata = '0;
    logic          io_ack;
    logic [DW-1:0] io_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_reply = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          overrun_err;
    logic          timeout_err;

    mem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .mem_read_from_pulse     (mem_read_from_pulse),
        .addr_from_sel           (addr_from_sel),
        .mem_read_reply_to_pulse (mem_read_reply_to_pulse),
        .rdata_to_ac             (rdata_to_ac),
        .io_req                  (io_req),
        .io_we                   (io_we),
        .io_addr                 (io_addr),
        .io_wdata                (io_wdata),
        .io_ack                  (io_ack),
        .io_rdata                (io_rdata),
        .mem_req                 (mem_req),
        .mem_we                  (mem_we),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_reply               (mem_reply),
        .mem_rdata               (mem_rdata),
        .overrun_err             (overrun_err),
        .timeout_err             (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        logic [63:0] h;
        h = 64'(i) * 64'h9E37_79B9_7F4A_7C15;
        if (i == 5) return DW'(37'h1234);
        return h[63-:DW];
    endfunction

    // Stimulus-owned controls for the memory responder
    int lat_cfg  = 3;
    int spur_cnt = 0;

    // Responder-owned memory and transaction log
    logic [DW-1:0] mem_arr  [0:4095];
    int            n_req = 0;
    int            spur_done = 0;
    logic [AW-1:0] req_addr [0:LOG_N-1];
    logic          req_we   [0:LOG_N-1];
    logic [DW-1:0] req_wdata[0:LOG_N-1];
    int            req_cyc  [0:LOG_N-1];
    int            rep_cyc  [0:LOG_N-1];

    initial begin : responder
        int cd;
        int cur;
        cd  = -1;
        cur = 0;
        for (int i = 0; i < 4096; i++) mem_arr[i] = init_word(i);
        forever begin
            @(negedge clk);
            mem_reply = 1'b0;
            if (mem_req === 1'b1) begin
                cur            = n_req % LOG_N;
                req_addr[cur]  = mem_addr;
                req_we[cur]    = mem_we;
                req_wdata[cur] = mem_wdata;
                req_cyc[cur]   = cyc;
                n_req++;
                cd = lat_cfg;
            end else if (cd > 0) begin
                cd--;
            end
            if (cd == 0) begin
                mem_reply = 1'b1;
                if (req_we[cur]) begin
                    mem_arr[req_addr[cur]] = req_wdata[cur];
                    mem_rdata = DW'({$urandom, $urandom});
                end else begin
                    mem_rdata = mem_arr[req_addr[cur]];
                end
                rep_cyc[cur] = cyc;
                cd = -1;
            end else if (spur_done != spur_cnt) begin
                mem_reply = 1'b1;
                mem_rdata = DW'({$urandom, $urandom});
                spur_done++;
            end
        end
    end

    // Monitor-owned log of owner pulses
    int            n_pul = 0;
    logic          pul_cpu [0:LOG_N-1];
    int            pul_cyc [0:LOG_N-1];
    logic [DW-1:0] pul_data[0:LOG_N-1];

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mem_read_reply_to_pulse === 1'b1) begin
                pul_cpu[n_pul % LOG_N]  = 1'b1;
                pul_cyc[n_pul % LOG_N]  = cyc;
                pul_data[n_pul % LOG_N] = rdata_to_ac;
                n_pul++;
            end
            if (io_ack === 1'b1) begin
                pul_cpu[n_pul % LOG_N]  = 1'b0;
                pul_cyc[n_pul % LOG_N]  = cyc;
                pul_data[n_pul % LOG_N] = io_rdata;
                n_pul++;
            end
        end
    end

    // Transaction-level reference model
    logic [DW-1:0] ref_mem [0:4095];
    bit            m_last_cpu;
    logic [DW-1:0] m_ac;
    logic [DW-1:0] m_io_rdata;

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},   64'(mem_req), 64'd0);
        check({tag, "_mem_we"},    64'(mem_we), 64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_cpu_pulse"}, 64'(mem_read_reply_to_pulse), 64'd0);
        check({tag, "_ac"},        64'(rdata_to_ac), 64'd0);
        check({tag, "_io_ack"},    64'(io_ack), 64'd0);
        check({tag, "_io_rdata"},  64'(io_rdata), 64'd0);
        check({tag, "_overrun"},   64'(overrun_err), 64'd0);
        check({tag, "_timeout"},   64'(timeout_err), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_read_from_pulse = 1'b0;
        io_req = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        m_last_cpu = 1'b0;
        m_ac       = '0;
        m_io_rdata = '0;
    endtask

    task automatic run_scn(input bit cpu_en, input logic [AW-1:0] ca, input bit io_en,
                           input bit we, input logic [AW-1:0] ia, input logic [DW-1:0] iw,
                           input int lat);
        int            c0, t, exp_n, base_req, base_pul, idx, pidx;
        bit            first_cpu, is_cpu;
        logic [DW-1:0] exp_data;
        lat_cfg = lat;
        @(negedge clk);
        c0       = cyc;
        base_req = n_req;
        base_pul = n_pul;
        exp_n    = int'(cpu_en) + int'(io_en);
        first_cpu = (cpu_en && io_en) ? !m_last_cpu : cpu_en;
        $display("txn cyc=%0d cpu=%0d addr=%03h io=%0d we=%0d io_addr=%03h lat=%0d",
                 c0, cpu_en, ca, io_en, we, ia, lat);
        if (cpu_en) begin
            mem_read_from_pulse = 1'b1;
            addr_from_sel = ca;
        end
        if (io_en) begin
            io_req   = 1'b1;
            io_we    = we;
            io_addr  = ia;
            io_wdata = iw;
        end
        @(negedge clk);
        mem_read_from_pulse = 1'b0;
        addr_from_sel = AW'($urandom);
        t = 0;
        while ((n_pul - base_pul) < exp_n && t < 200) begin
            if (io_ack === 1'b1) io_req = 1'b0;
            @(negedge clk);
            t++;
        end
        io_req = 1'b0;
        repeat (4) @(negedge clk);

        check("req_count", 64'(n_req - base_req), 64'(exp_n));
        check("pulse_count", 64'(n_pul - base_pul), 64'(exp_n));
        for (int k = 0; k < exp_n; k++) begin
            idx    = (base_req + k) % LOG_N;
            pidx   = (base_pul + k) % LOG_N;
            is_cpu = (k == 0) ? first_cpu : !first_cpu;
            if (k == 0) check("issue_latency", 64'(req_cyc[idx] - c0), is_cpu ? 64'd2 : 64'd1);
            check("mem_addr", 64'(req_addr[idx]), 64'(is_cpu ? ca : ia));
            check("mem_we", 64'(req_we[idx]), 64'(is_cpu ? 1'b0 : we));
            check("mem_wdata", 64'(req_wdata[idx]), 64'(is_cpu ? {DW{1'b0}} : iw));
            check("owner_is_cpu", 64'(pul_cpu[pidx]), 64'(is_cpu));
            check("reply_latency", 64'(pul_cyc[pidx] - rep_cyc[idx]), 64'd1);
            if (is_cpu) begin
                exp_data = ref_mem[ca];
                m_ac = exp_data;
            end else if (we) begin
                exp_data = m_io_rdata;
                ref_mem[ia] = iw;
            end else begin
                exp_data = ref_mem[ia];
                m_io_rdata = exp_data;
            end
            check("reply_data", 64'(pul_data[pidx]), 64'(exp_data));
            m_last_cpu = is_cpu;
        end
        check("ac_hold", 64'(rdata_to_ac), 64'(m_ac));
        check("io_rdata_hold", 64'(io_rdata), 64'(m_io_rdata));
        check("mem_req_idle", 64'(mem_req), 64'd0);
    endtask

    task automatic spurious_reply_test();
        int bpul, breq;
        bpul = n_pul;
        breq = n_req;
        @(negedge clk);
        spur_cnt++;
        repeat (6) @(negedge clk);
        check("spur_no_pulse", 64'(n_pul - bpul), 64'd0);
        check("spur_no_req", 64'(n_req - breq), 64'd0);
        check("spur_ac_hold", 64'(rdata_to_ac), 64'(m_ac));
    endtask

    task automatic overrun_test();
        int breq, bpul, t;
        check("overrun_clear", 64'(overrun_err), 64'd0);
        lat_cfg = 6;
        @(negedge clk);
        breq = n_req;
        bpul = n_pul;
        mem_read_from_pulse = 1'b1;
        addr_from_sel = 12'h0A0;
        @(negedge clk);
        mem_read_from_pulse = 1'b0;
        t = 0;
        while (n_req == breq && t < 20) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        mem_read_from_pulse = 1'b1;
        addr_from_sel = 12'h0B0;
        @(negedge clk);
        mem_read_from_pulse = 1'b0;
        t = 0;
        while (n_pul == bpul && t < 50) begin @(negedge clk); t++; end
        repeat (6) @(negedge clk);
        $display("txn overrun pair addr=0a0/0b0 cyc=%0d", cyc);
        m_ac = ref_mem[12'h0A0];
        m_last_cpu = 1'b1;
        check("overrun_set", 64'(overrun_err), 64'd1);
        check("overrun_one_req", 64'(n_req - breq), 64'd1);
        check("overrun_addr", 64'(req_addr[breq % LOG_N]), 64'h0A0);
        check("overrun_one_pulse", 64'(n_pul - bpul), 64'd1);
        check("overrun_data", 64'(rdata_to_ac), 64'(m_ac));
    endtask

    task automatic reset_in_wait_test();
        int breq, bpul, t;
        lat_cfg = 4;
        @(negedge clk);
        breq = n_req;
        bpul = n_pul;
        mem_read_from_pulse = 1'b1;
        addr_from_sel = 12'h033;
        @(negedge clk);
        mem_read_from_pulse = 1'b0;
        t = 0;
        while (n_req == breq && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        $display("txn reset-in-wait addr=033 cyc=%0d", cyc);
        check("rstw_no_pulse", 64'(n_pul - bpul), 64'd0);
        check("rstw_one_req", 64'(n_req - breq), 64'd1);
        check("rstw_mem_req", 64'(mem_req), 64'd0);
        check("rstw_ac", 64'(rdata_to_ac), 64'd0);
        check("rstw_overrun", 64'(overrun_err), 64'd0);
        m_last_cpu = 1'b0;
        m_ac       = '0;
        m_io_rdata = '0;
    endtask

    task automatic no_reply_test();
        int breq, bpul, t;
        lat_cfg = NO_REPLY;
        @(negedge clk);
        breq = n_req;
        bpul = n_pul;
        mem_read_from_pulse = 1'b1;
        addr_from_sel = 12'h044;
        @(negedge clk);
        mem_read_from_pulse = 1'b0;
        t = 0;
        while (n_req == breq && t < 20) begin @(negedge clk); t++; end
        $display("txn no-reply addr=044 cyc=%0d", cyc);
`ifdef MEM_TIMEOUT_EN
        t = 0;
        while (n_pul == bpul && t < 40) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        check("to_pulse", 64'(n_pul - bpul), 64'd1);
        check("to_latency", 64'(pul_cyc[bpul % LOG_N] - req_cyc[breq % LOG_N]), 64'(TO + 1));
        check("to_ac_zero", 64'(rdata_to_ac), 64'd0);
        check("to_err", 64'(timeout_err), 64'd1);
`else
        repeat (1000) @(negedge clk);
        check("hang_no_pulse", 64'(n_pul - bpul), 64'd0);
        check("hang_timeout_err", 64'(timeout_err), 64'd0);
        check("hang_one_req", 64'(n_req - breq), 64'd1);
        check("hang_addr_held", 64'(mem_addr), 64'h044);
`endif
        do_reset();
    endtask

    initial begin : main
        int sel;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        m_last_cpu = 1'b0;
        m_ac       = '0;
        m_io_rdata = '0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        reset = 1'b0;

        run_scn(1'b1, 12'h005, 1'b0, 1'b0, 12'h000, '0, 3);
        check("t1_ac", 64'(rdata_to_ac), 64'h1234);
        run_scn(1'b0, 12'h000, 1'b1, 1'b1, 12'h7FF, 37'h0AAAA, 2);
        run_scn(1'b1, 12'h7FF, 1'b0, 1'b0, 12'h000, '0, 1);
        spurious_reply_test();

        do_reset();
        run_scn(1'b1, 12'h010, 1'b1, 1'b0, 12'h011, '0, 2);
        run_scn(1'b1, 12'h020, 1'b0, 1'b0, 12'h000, '0, 1);
        run_scn(1'b1, 12'h012, 1'b1, 1'b1, 12'h013, DW'(37'h1_2345_6789), 0);

        overrun_test();
        reset_in_wait_test();
        run_scn(1'b0, 12'h000, 1'b1, 1'b0, 12'h013, '0, 2);
        no_reply_test();

        for (int n = 0; n < 120; n++) begin
            sel = int'($urandom_range(0, 2));
            run_scn(sel != 1, AW'($urandom_range(0, 15)), sel != 0, 1'($urandom),
                    AW'($urandom_range(0, 15)), DW'({$urandom, $urandom}),
                    int'($urandom_range(0, 5)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
